// File: rtl/ibex_data_bus_arbiter.sv
// ibex_data_bus_arbiter: two-host round-robin arbiter for the data bus with an in-order response-owner FIFO.
// Define IBEX_DBA_FIXED_PRIO_EN to give host 0 (LSU) fixed priority instead of round-robin.
module ibex_data_bus_arbiter #(
  parameter int unsigned MemDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    h0_req_i,
  output logic                    h0_gnt_o,
  output logic                    h0_rvalid_o,
  output logic                    h0_err_o,
  input  logic [31:0]             h0_addr_i,
  input  logic                    h0_we_i,
  input  logic [3:0]              h0_be_i,
  input  logic [MemDataWidth-1:0] h0_wdata_i,
  output logic [MemDataWidth-1:0] h0_rdata_o,
  input  logic                    h1_req_i,
  output logic                    h1_gnt_o,
  output logic                    h1_rvalid_o,
  output logic                    h1_err_o,
  input  logic [31:0]             h1_addr_i,
  input  logic                    h1_we_i,
  input  logic [3:0]              h1_be_i,
  input  logic [MemDataWidth-1:0] h1_wdata_i,
  output logic [MemDataWidth-1:0] h1_rdata_o,
  output logic                    data_req_o,
  output logic [31:0]             data_addr_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [MemDataWidth-1:0] data_wdata_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic                    data_err_i,
  input  logic [MemDataWidth-1:0] data_rdata_i,
  output logic                    resp_unexp_o,
  output logic                    busy_o
);
  localparam int unsigned PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  logic                      lock_q, lock_owner_q, prio, sel, grant, pop, head, empty, full;
  logic [MaxOutstanding-1:0] owner_q;
  logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]           cnt_q;
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction
`ifdef IBEX_DBA_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic prio_q;
  assign prio = prio_q;
`endif
  // A locked request keeps its owner; otherwise priority only matters under contention.
  assign sel          = lock_q ? lock_owner_q : (h0_req_i & h1_req_i) ? prio : h1_req_i;
  assign empty        = cnt_q == '0;
  assign full         = cnt_q == CntW'(MaxOutstanding);
  assign data_req_o   = rst_ni & (lock_q | ((h0_req_i | h1_req_i) & ~full));
  assign grant        = data_req_o & data_gnt_i;
  assign h0_gnt_o     = grant & ~sel;
  assign h1_gnt_o     = grant & sel;
  assign data_addr_o  = sel ? h1_addr_i : h0_addr_i;
  assign data_we_o    = sel ? h1_we_i : h0_we_i;
  assign data_be_o    = sel ? h1_be_i : h0_be_i;
  assign data_wdata_o = sel ? h1_wdata_i : h0_wdata_i;
  assign head         = owner_q[rd_ptr_q];
  assign pop          = data_rvalid_i & ~empty;
  assign resp_unexp_o = rst_ni & data_rvalid_i & empty;
  assign h0_rvalid_o  = pop & ~head;
  assign h1_rvalid_o  = pop & head;
  assign h0_err_o     = h0_rvalid_o & data_err_i;
  assign h1_err_o     = h1_rvalid_o & data_err_i;
  assign h0_rdata_o   = data_rdata_i;
  assign h1_rdata_o   = data_rdata_i;
  assign busy_o       = lock_q | ~empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      owner_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
`ifndef IBEX_DBA_FIXED_PRIO_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      if (grant) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q  <= cnt_q + CntW'(grant) - CntW'(pop);
      lock_q <= data_req_o & ~data_gnt_i;
      if (data_req_o & ~data_gnt_i) lock_owner_q <= sel;
`ifndef IBEX_DBA_FIXED_PRIO_EN
      if (grant) prio_q <= ~sel;
`endif
    end
  end
endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// tb_ibex_data_bus_arbiter: directed and randomized checks of the arbiter against a queue-based reference model.
module tb_ibex_data_bus_arbiter;
  localparam int MAXO = 2;
`ifdef IBEX_DBA_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst_ni = 1'b0;
  logic h0_req_i = 0, h0_gnt_o, h0_rvalid_o, h0_err_o, h0_we_i = 0;
  logic h1_req_i = 0, h1_gnt_o, h1_rvalid_o, h1_err_o, h1_we_i = 0;
  logic [31:0] h0_addr_i = 0, h1_addr_i = 0, h0_wdata_i = 0, h1_wdata_i = 0, h0_rdata_o, h1_rdata_o;
  logic [3:0] h0_be_i = 0, h1_be_i = 0, data_be_o;
  logic data_req_o, data_we_o, data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0, resp_unexp_o, busy_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ibex_data_bus_arbiter #(.MemDataWidth(32), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .h0_req_i(h0_req_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o), .h0_err_o(h0_err_o),
    .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i), .h0_wdata_i(h0_wdata_i), .h0_rdata_o(h0_rdata_o),
    .h1_req_i(h1_req_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o), .h1_err_o(h1_err_o),
    .h1_addr_i(h1_addr_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i), .h1_wdata_i(h1_wdata_i), .h1_rdata_o(h1_rdata_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_rdata_i(data_rdata_i), .resp_unexp_o(resp_unexp_o), .busy_o(busy_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Reference model: owners of granted transactions in a queue, a pending (ungranted) presentation, and the priority host.
  int q[$];
  bit m_lock;
  int m_lo, m_prio;
  always @(negedge clk) begin : model
    int sel;
    bit ereq, eg;
    logic [1:0] exp_rv, exp_err;
    bit exp_unexp;
    if (!rst_ni) begin
      q.delete();
      m_lock = 0;
      m_prio = 0;
      chk("reset_outputs", {data_req_o, h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o, h0_err_o, h1_err_o,
                            resp_unexp_o, busy_o}, 0);
    end else begin
      if (m_lock) sel = m_lo;
      else if (h0_req_i && h1_req_i) sel = FIXED ? 0 : m_prio;
      else sel = h1_req_i ? 1 : 0;
      ereq = m_lock || ((h0_req_i || h1_req_i) && q.size() < MAXO);
      eg = ereq && data_gnt_i;
      chk("model_req", data_req_o, ereq);
      chk("model_gnt", {h1_gnt_o, h0_gnt_o}, eg ? (sel == 1 ? 2'b10 : 2'b01) : 2'b00);
      if (ereq) begin
        chk("model_addr", data_addr_o, sel == 1 ? h1_addr_i : h0_addr_i);
        chk("model_attr", {data_we_o, data_be_o, data_wdata_o},
            sel == 1 ? {h1_we_i, h1_be_i, h1_wdata_i} : {h0_we_i, h0_be_i, h0_wdata_i});
      end
      exp_rv = 2'b00;
      exp_err = 2'b00;
      exp_unexp = 0;
      if (data_rvalid_i) begin
        if (q.size() > 0) begin
          exp_rv = q[0] == 1 ? 2'b10 : 2'b01;
          exp_err = data_err_i ? exp_rv : 2'b00;
        end else exp_unexp = 1;
      end
      chk("model_rvalid", {h1_rvalid_o, h0_rvalid_o}, exp_rv);
      chk("model_err", {h1_err_o, h0_err_o}, exp_err);
      chk("model_unexp", resp_unexp_o, exp_unexp);
      chk("model_rdata", {h1_rdata_o, h0_rdata_o}, {data_rdata_i, data_rdata_i});
      chk("model_busy", busy_o, q.size() > 0 || m_lock);
      if (data_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (eg) begin
        q.push_back(sel);
        m_prio = 1 - sel;
        m_lock = 0;
      end else if (ereq) begin
        m_lock = 1;
        m_lo = sel;
      end
    end
  end
  initial begin
    bit g0, g1;
    logic [1:0] g;
    step;
    h0_req_i = 1;
    @(negedge clk);
    chk("reset_req_gated", data_req_o, 0);
    step;
    rst_ni = 1;
    h0_req_i = 0;
    // single host 0 load
    h0_req_i = 1; h0_addr_i = 32'h100; h0_be_i = 4'hf; data_gnt_i = 1;
    @(negedge clk);
    chk("t1_gnt", h0_gnt_o, 1);
    chk("t1_addr", data_addr_o, 32'h100);
    step;
    h0_req_i = 0; data_gnt_i = 0;
    step;
    data_rvalid_i = 1; data_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_h0_rvalid", h0_rvalid_o, 1);
    chk("t1_h1_rvalid", h1_rvalid_o, 0);
    chk("t1_rdata", h0_rdata_o, 32'hDEADBEEF);
    step;
    data_rvalid_i = 0;
    // contention with continuous grant: h0 was granted last
    h0_req_i = 1; h1_req_i = 1; h0_addr_i = 32'h200; h1_addr_i = 32'h300; data_gnt_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = {h1_gnt_o, h0_gnt_o};
      chk($sformatf("t2_grant%0d", i), g, FIXED ? 2'b01 : ((i % 2 == 0) ? 2'b10 : 2'b01));
      step;
      data_rvalid_i = 1;
    end
    h0_req_i = 0; h1_req_i = 0; data_gnt_i = 0;
    step;
    data_rvalid_i = 0;
    // lock: device stalls while both request
    h0_req_i = 1; h1_req_i = 1; h0_addr_i = 32'hA0; h1_addr_i = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_lock_addr%0d", i), data_addr_o, FIXED ? 32'hA0 : 32'hB0);
      step;
    end
    data_gnt_i = 1;
    @(negedge clk);
    chk("t3_first_gnt", {h1_gnt_o, h0_gnt_o}, FIXED ? 2'b01 : 2'b10);
    step;
    if (FIXED) h0_req_i = 0; else h1_req_i = 0;
    @(negedge clk);
    chk("t3_second_gnt", {h1_gnt_o, h0_gnt_o}, FIXED ? 2'b10 : 2'b01);
    step;
    h0_req_i = 0; h1_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    step;
    step;
    data_rvalid_i = 0;
    // capacity limit
    h0_req_i = 1; data_gnt_i = 1;
    @(negedge clk);
    chk("t4_gnt_a", h0_gnt_o, 1);
    step;
    @(negedge clk);
    chk("t4_gnt_b", h0_gnt_o, 1);
    step;
    @(negedge clk);
    chk("t4_full_req", data_req_o, 0);
    step;
    data_rvalid_i = 1;
    @(negedge clk);
    chk("t4_pop_not_counted", data_req_o, 0);
    step;
    data_rvalid_i = 0;
    @(negedge clk);
    chk("t4_req_rises", data_req_o, 1);
    step;
    h0_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1;
    step;
    step;
    data_rvalid_i = 0;
    // ordering and error routing
    h0_req_i = 1; data_gnt_i = 1;
    step;
    h0_req_i = 0; h1_req_i = 1;
    step;
    h1_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_err_i = 0;
    @(negedge clk);
    chk("t5_first_rv", {h1_rvalid_o, h0_rvalid_o, h0_err_o}, 3'b010);
    step;
    data_err_i = 1;
    @(negedge clk);
    chk("t5_second_rv", {h1_rvalid_o, h0_rvalid_o, h1_err_o}, 3'b101);
    step;
    data_rvalid_i = 0; data_err_i = 0;
    // reset with outstanding transactions, then a late response
    h0_req_i = 1; data_gnt_i = 1;
    step;
    step;
    h0_req_i = 0; data_gnt_i = 0; rst_ni = 0;
    step;
    rst_ni = 1; data_rvalid_i = 1;
    @(negedge clk);
    chk("t6_unexp", {resp_unexp_o, h1_rvalid_o, h0_rvalid_o, busy_o}, 4'b1000);
    step;
    data_rvalid_i = 0;
    @(negedge clk);
    chk("t6_unexp_pulse", {resp_unexp_o, busy_o}, 2'b00);
    // randomized traffic obeying the hold-until-grant rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = h0_gnt_o;
      g1 = h1_gnt_o;
      @(posedge clk);
      #1;
      if (h0_req_i && g0) h0_req_i = 0;
      if (h1_req_i && g1) h1_req_i = 0;
      if (!rst_ni) rst_ni = 1;
      else if ($urandom_range(0, 399) == 0) begin
        rst_ni = 0; h0_req_i = 0; h1_req_i = 0;
      end
      if (rst_ni && !h0_req_i && $urandom_range(0, 2) == 0) begin
        h0_req_i = 1; h0_addr_i = $urandom; h0_we_i = 1'($urandom); h0_be_i = 4'($urandom); h0_wdata_i = $urandom;
      end
      if (rst_ni && !h1_req_i && $urandom_range(0, 2) == 0) begin
        h1_req_i = 1; h1_addr_i = $urandom; h1_we_i = 1'($urandom); h1_be_i = 4'($urandom); h1_wdata_i = $urandom;
      end
      data_gnt_i = 1'($urandom);
      data_rvalid_i = $urandom_range(0, 9) < 4;
      data_err_i = 1'($urandom);
      data_rdata_i = $urandom;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
